saturating_counter_table: RTL and testbench



---
 rtl/saturating_counter_table.sv | 152 +++++++++++++++
 tb/tb_saturating_counter_table.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/saturating_counter_table.sv
// saturating_counter_table
//   DEPTH independent saturating counters (0..RANGE-1) in a flop array, with one
//   lookup port (1-cycle latency) and one read-modify-write update port.
//   After reset an init sweep writes RESET_VALUE to every entry, one per cycle,
//   before ready rises.
//   Optional feature: define SATURATING_COUNTER_TABLE_BYPASS_EN for write-first
//   behaviour on a same-cycle lookup/update of one index. Without it the lookup
//   returns the pre-update value.
module saturating_counter_table #(
    parameter int DEPTH       = 16,
    parameter int RANGE       = 4,
    parameter int RESET_VALUE = 1,
    localparam int INDEX_WIDTH = $clog2(DEPTH),
    localparam int WIDTH       = $clog2(RANGE)
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   ready,
    input  logic                   read_enable,
    input  logic [INDEX_WIDTH-1:0] read_index,
    output logic                   read_valid,
    output logic [WIDTH-1:0]       read_count,
    input  logic                   update_enable,
    input  logic [INDEX_WIDTH-1:0] update_index,
    input  logic                   update_increment
);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    // Saturation limit held one bit wider so that a non-power-of-two RANGE
    // stops at RANGE-1 rather than at the all-ones value of WIDTH bits.
    localparam logic [WIDTH:0]         MAX_WIDE   = (WIDTH+1)'(RANGE - 1);
    localparam logic [WIDTH-1:0]       INIT_VALUE = WIDTH'(RESET_VALUE);
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(DEPTH - 1);

    state_t                 state_q;
    logic [INDEX_WIDTH-1:0] init_ptr_q;
    logic                   ready_q;
    logic                   read_valid_q;
    logic [WIDTH-1:0]       read_count_q;

    logic [WIDTH-1:0]       table_q [DEPTH];

    logic                   update_fire;
    logic [WIDTH-1:0]       update_old;
    logic [WIDTH:0]         update_sum;
    logic [WIDTH-1:0]       update_inc;
    logic [WIDTH-1:0]       update_dec;
    logic [WIDTH-1:0]       update_new;

    logic                   write_en;
    logic [INDEX_WIDTH-1:0] write_index;
    logic [WIDTH-1:0]       entry_d;

    logic [WIDTH-1:0]       read_data;

    // An update is only accepted while the table is up and reset is not asserted.
    assign update_fire = (state_q == ST_READY) && update_enable && !reset;

    // Saturating next value for the addressed entry.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path first, so no latch is inferred.
        update_old = table_q[update_index];
        update_sum = {1'b0, update_old} + (WIDTH+1)'(1);
        update_inc = update_old;
        update_dec = update_old;
        if (update_sum <= MAX_WIDE) begin
            update_inc = update_sum[WIDTH-1:0];
        end
        if (update_old != '0) begin
            update_dec = update_old - WIDTH'(1);
        end
        update_new = update_increment ? update_inc : update_dec;
    end

    // Single write port: the init sweep owns it in INIT, the update port in READY.
    always_comb begin
        write_en    = 1'b0;
        write_index = update_index;
        entry_d     = update_new;
        if (!reset) begin
            if (state_q == ST_INIT) begin
                write_en    = 1'b1;
                write_index = init_ptr_q;
                entry_d     = INIT_VALUE;
            end else if (update_fire) begin
                write_en = 1'b1;
            end
        end
    end

    // Lookup data: read-first by default, write-first when the bypass is built.
    always_comb begin
`ifdef SATURATING_COUNTER_TABLE_BYPASS_EN
        read_data = table_q[read_index];
        if (update_fire && (update_index == read_index)) begin
            read_data = update_new;
        end
`else
        read_data = table_q[read_index];
`endif
    end

    // Counter storage; contents survive reset and are rebuilt by the init sweep.
    always_ff @(posedge clock) begin
        // NOTE: the storage array has no reset branch; the sweep initialises it, which keeps it a plain flop array without a reset tree.
        if (write_en) begin
            table_q[write_index] <= entry_d;
        end
    end

    // Control FSM: INIT sweep, then READY serving lookups, with registered outputs.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q      <= ST_INIT;
            init_ptr_q   <= '0;
            ready_q      <= 1'b0;
            read_valid_q <= 1'b0;
            read_count_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    read_valid_q <= 1'b0;
                    init_ptr_q   <= init_ptr_q + INDEX_WIDTH'(1);
                    if (init_ptr_q == LAST_INDEX) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    read_valid_q <= read_enable;
                    if (read_enable) begin
                        read_count_q <= read_data;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign read_valid = read_valid_q;
    assign read_count = read_count_q;

endmodule

// File: tb/tb_saturating_counter_table.sv
// Testbench for saturating_counter_table.
// DUT a: DEPTH=16, RANGE=4, RESET_VALUE=1. DUT b: DEPTH=16, RANGE=3, RESET_VALUE=1.
// Stimulus pushes expected lookup results into per-DUT queues; a monitor pops
// and compares whenever read_valid is seen.
module tb_saturating_counter_table;

`ifdef SATURATING_COUNTER_TABLE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int RANGE_B = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       a_ready, a_read_enable, a_read_valid, a_update_enable, a_update_increment;
    logic [3:0] a_read_index, a_update_index;
    logic [1:0] a_read_count;

    logic       b_ready, b_read_enable, b_read_valid, b_update_enable, b_update_increment;
    logic [3:0] b_read_index, b_update_index;
    logic [1:0] b_read_count;

    int checks = 0;
    int errors = 0;
    int qa[$];
    int qb[$];
    int bm[16];

    int sat_up[4]   = '{2, 3, 3, 3};
    int sat_down[5] = '{2, 1, 0, 0, 0};

    always #5 clock = ~clock;

    saturating_counter_table #(.DEPTH(16), .RANGE(4), .RESET_VALUE(1)) dut_a (
        .clock(clock), .reset(reset), .ready(a_ready),
        .read_enable(a_read_enable), .read_index(a_read_index),
        .read_valid(a_read_valid), .read_count(a_read_count),
        .update_enable(a_update_enable), .update_index(a_update_index),
        .update_increment(a_update_increment)
    );

    saturating_counter_table #(.DEPTH(16), .RANGE(RANGE_B), .RESET_VALUE(1)) dut_b (
        .clock(clock), .reset(reset), .ready(b_ready),
        .read_enable(b_read_enable), .read_index(b_read_index),
        .read_valid(b_read_valid), .read_count(b_read_count),
        .update_enable(b_update_enable), .update_index(b_update_index),
        .update_increment(b_update_increment)
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int cycles = 0;
        while (!a_ready && cycles < 100) begin
            step();
            cycles++;
        end
        check(name, cycles, 16);
    endtask

    task automatic a_lookup(input int idx, input int exp);
        a_read_enable = 1'b1;
        a_read_index  = 4'(idx);
        qa.push_back(exp);
        step();
        a_read_enable = 1'b0;
    endtask

    task automatic a_update(input int idx, input bit inc);
        a_update_enable    = 1'b1;
        a_update_index     = 4'(idx);
        a_update_increment = inc;
        step();
        a_update_enable = 1'b0;
    endtask

    function automatic int sat_b(input int v, input bit inc);
        if (inc) return (v == RANGE_B - 1) ? v : v + 1;
        return (v == 0) ? 0 : v - 1;
    endfunction

    task automatic b_lookup(input int idx, input int exp);
        b_read_enable = 1'b1;
        b_read_index  = 4'(idx);
        qb.push_back(exp);
        step();
        b_read_enable = 1'b0;
    endtask

    task automatic b_update(input int idx, input bit inc);
        b_update_enable    = 1'b1;
        b_update_index     = 4'(idx);
        b_update_increment = inc;
        bm[idx] = sat_b(bm[idx], inc);
        step();
        b_update_enable = 1'b0;
    endtask

    // Monitor: every read_valid must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (a_read_valid === 1'b1) begin
            if (qa.size() == 0) check("a_spurious_valid", 1, 0);
            else check("a_read_count", int'(a_read_count), qa.pop_front());
        end
        if (b_read_valid === 1'b1) begin
            if (qb.size() == 0) check("b_spurious_valid", 1, 0);
            else check("b_read_count", int'(b_read_count), qb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        a_read_enable = 0; a_read_index = 0; a_update_enable = 0; a_update_index = 0; a_update_increment = 0;
        b_read_enable = 0; b_read_index = 0; b_update_enable = 0; b_update_index = 0; b_update_increment = 0;

        // Reset state and init sweep.
        reset = 1'b1;
        step();
        check("reset_ready", int'(a_ready), 0);
        check("reset_read_valid", int'(a_read_valid), 0);
        check("reset_read_count", int'(a_read_count), 0);
        reset = 1'b0;
        wait_ready("init_ready_low_cycles");
        check("b_ready", int'(b_ready), 1);
        for (int i = 0; i < 16; i++) a_lookup(i, 1);
        step();
        check("read_valid_pulse_drops", int'(a_read_valid), 0);
        check("read_count_holds", int'(a_read_count), 1);

        // Saturation up and down on index 3.
        for (int i = 0; i < 4; i++) begin
            a_update(3, 1'b1);
            a_lookup(3, sat_up[i]);
        end
        for (int i = 0; i < 5; i++) begin
            a_update(3, 1'b0);
            a_lookup(3, sat_down[i]);
        end
        a_lookup(4, 1);

        // Same-cycle collision on index 5 (value 1).
        a_read_enable      = 1'b1;
        a_read_index       = 4'd5;
        a_update_enable    = 1'b1;
        a_update_index     = 4'd5;
        a_update_increment = 1'b1;
        qa.push_back(BYPASS ? 2 : 1);
        step();
        a_read_enable   = 1'b0;
        a_update_enable = 1'b0;
        a_lookup(5, 2);
        step();

        // Requests during INIT are ignored.
        do_reset();
        step();
        step();
        a_update_enable = 1'b1; a_update_index = 4'd2; a_update_increment = 1'b1;
        a_read_enable   = 1'b1; a_read_index   = 4'd2;
        begin
            int cycles = 2;
            while (!a_ready && cycles < 100) begin
                step();
                cycles++;
                check("init_read_valid_low", int'(a_read_valid), 0);
            end
            a_update_enable = 1'b0;
            a_read_enable   = 1'b0;
            check("init2_ready_low_cycles", cycles, 16);
        end
        a_lookup(2, 1);
        a_lookup(5, 1);

        // Reset mid-operation and mid-sweep.
        a_update(7, 1'b1);
        a_update(7, 1'b1);
        a_lookup(7, 3);
        step();
        do_reset();
        repeat (8) step();
        check("mid_sweep_ready_low", int'(a_ready), 0);
        do_reset();
        wait_ready("mid_reset_ready_low_cycles");
        a_lookup(7, 1);

        // Non-power-of-two RANGE=3: saturates at 2.
        for (int i = 0; i < 16; i++) bm[i] = 1;
        for (int i = 0; i < 5; i++) begin
            b_update(0, 1'b1);
            b_lookup(0, 2);
        end

        // Random traffic on DUT b against the reference model.
        for (int n = 0; n < 1000; n++) begin
            bit re, ue, inc;
            int ri, ui, exp;
            re  = 1'($urandom_range(0, 1));
            ue  = 1'($urandom_range(0, 1));
            inc = 1'($urandom_range(0, 1));
            ri  = $urandom_range(0, 15);
            ui  = $urandom_range(0, 15);
            if (n % 7 == 0) ui = ri;
            b_read_enable      = re;
            b_read_index       = 4'(ri);
            b_update_enable    = ue;
            b_update_index     = 4'(ui);
            b_update_increment = inc;
            if (re) begin
                exp = bm[ri];
                if (BYPASS && ue && (ui == ri)) exp = sat_b(bm[ri], inc);
                qb.push_back(exp);
            end
            if (ue) bm[ui] = sat_b(bm[ui], inc);
            step();
        end
        b_read_enable   = 1'b0;
        b_update_enable = 1'b0;

        repeat (3) step();
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
